// File: rtl/dlfloat_pkg.sv
// Shared definitions for the DLFloat16 MAC sequencer.
//   - DLFloat16 field widths: 1 sign bit, 6 exponent bits (bias 31), 9 mantissa bits
//   - common constants: zero and one
//   - sequencer state encoding
package dlfloat_pkg;

   localparam int SIGN_W = 1;
   localparam int EXP_W  = 6;
   localparam int MAN_W  = 9;
   localparam int BIAS   = 31;
   localparam int DLF_W  = SIGN_W + EXP_W + MAN_W;

   localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
   // 1.0 is a positive sign, a biased exponent equal to the bias, and an all-zero mantissa (16'h3E00).
   localparam logic [DLF_W-1:0] DLF_ONE  = {{SIGN_W{1'b0}}, EXP_W'(BIAS), {MAN_W{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/dlfloat_byte_packer.sv
// Assembles one operand pair from four bytes.
// Byte order: a[7:0], a[15:8], b[7:0], b[15:8].
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart assembly at byte 0 (job start)
//   take       - a byte transfers this cycle
//   in_data    - the byte
//   pair       - {a, b}; the final byte is forwarded straight from in_data,
//                so pair is complete in the cycle that pair_done is high
//   pair_done  - the fourth byte of a pair transfers this cycle
module dlfloat_byte_packer
   import dlfloat_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               take,
   input  logic [7:0]         in_data,
   output logic [2*DLF_W-1:0] pair,
   output logic               pair_done
);

   logic [1:0] byte_idx_r;
   logic [7:0] a_lo_r;
   logic [7:0] a_hi_r;
   logic [7:0] b_lo_r;

   // Byte counter (wraps 3 -> 0) and the first three bytes of the pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_r <= 2'd0;
         a_lo_r     <= 8'h00;
         a_hi_r     <= 8'h00;
         b_lo_r     <= 8'h00;
      end else if (clr) begin
         byte_idx_r <= 2'd0;
      end else if (take) begin
         byte_idx_r <= byte_idx_r + 2'd1;
         case (byte_idx_r)
            2'd0:    a_lo_r <= in_data;
            2'd1:    a_hi_r <= in_data;
            2'd2:    b_lo_r <= in_data;
            default: b_lo_r <= b_lo_r;   // last byte is used directly from in_data
         endcase
      end else begin
         byte_idx_r <= byte_idx_r;
      end
   end

   // Completed pair and its strobe.
   always_comb begin
      pair      = {a_hi_r, a_lo_r, in_data, b_lo_r};
      pair_done = take & (byte_idx_r == 2'd3);
   end

endmodule

// File: rtl/dlfloat_mac_seq.sv
// Feeds the DLFloat16 MAC from a byte-wide stream and returns a dot-product result.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start, cfg_len       - begin a job of cfg_len operand pairs (accepted only when idle)
//   in_data/valid/ready  - operand byte stream
//   mac_a, mac_b         - operands to the MAC
//   mac_en, mac_clr      - one-cycle strobes: consume operands / clear the accumulator
//   mac_result           - MAC accumulator output (valid MAC_LAT cycles after mac_en)
//   res_data/valid/ready - job result port
//   busy                 - high in every state except IDLE
module dlfloat_mac_seq
   import dlfloat_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic             mac_en,
   output logic             mac_clr,
   input  logic [15:0]      mac_result,
   output logic [15:0]      res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   localparam int                 DRAIN_W    = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MAC_LAT);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
   localparam logic [LEN_W-1:0]   LEN_ZERO   = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);

   seq_state_t          state_r;
   logic [LEN_W-1:0]    len_r;
   logic [LEN_W-1:0]    prod_cnt_r;
   logic [DRAIN_W-1:0]  drain_cnt_r;
   logic                in_ready_r;
   logic                mac_en_r;
   logic                mac_clr_r;
   logic [DLF_W-1:0]    mac_a_r;
   logic [DLF_W-1:0]    mac_b_r;
   logic [DLF_W-1:0]    res_data_r;
   logic                res_valid_r;
   logic                busy_r;

   logic                take_s;
   logic                job_start_s;
   logic [LEN_W-1:0]    prod_nxt_s;
   logic [2*DLF_W-1:0]  pair_s;
   logic                pair_done_s;

   // Byte handshake, job-start detection and the incremented product count.
   always_comb begin
      take_s     = in_valid & in_ready_r;
      prod_nxt_s = prod_cnt_r + LEN_ONE;
      if ((state_r == ST_IDLE) && start && (cfg_len != LEN_ZERO)) begin
         job_start_s = 1'b1;
      end else begin
         job_start_s = 1'b0;
      end
   end

   dlfloat_byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (job_start_s),
      .take      (take_s),
      .in_data   (in_data),
      .pair      (pair_s),
      .pair_done (pair_done_s)
   );

   // Sequencer FSM with counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         len_r       <= LEN_ZERO;
         prod_cnt_r  <= LEN_ZERO;
         drain_cnt_r <= DRAIN_ZERO;
         in_ready_r  <= 1'b0;
         mac_en_r    <= 1'b0;
         mac_clr_r   <= 1'b0;
         mac_a_r     <= DLF_ZERO;
         mac_b_r     <= DLF_ZERO;
         res_data_r  <= DLF_ZERO;
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a transition below raises them.
         mac_en_r  <= 1'b0;
         mac_clr_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (job_start_s) begin
                  len_r      <= cfg_len;
                  prod_cnt_r <= LEN_ZERO;
                  mac_clr_r  <= 1'b1;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b1;
                  state_r    <= ST_LOAD;
               end else if (start) begin
                  // Empty job: result is zero, the MAC is never touched.
                  res_data_r  <= DLF_ZERO;
                  res_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (pair_done_s) begin
                  mac_a_r    <= pair_s[2*DLF_W-1:DLF_W];
                  mac_b_r    <= pair_s[DLF_W-1:0];
                  in_ready_r <= 1'b0;
                  mac_en_r   <= 1'b1;
                  state_r    <= ST_ISSUE;
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_ISSUE: begin
               prod_cnt_r <= prod_nxt_s;
               if (prod_nxt_s == len_r) begin
                  drain_cnt_r <= DRAIN_LOAD;
                  state_r     <= ST_DRAIN;
               end else begin
                  in_ready_r <= 1'b1;
                  state_r    <= ST_LOAD;
               end
            end
            ST_DRAIN: begin
               // Capture in the cycle the count reaches zero: that is MAC_LAT
               // cycles after mac_en, when mac_result includes the last product.
               if (drain_cnt_r <= DRAIN_ONE) begin
                  drain_cnt_r <= DRAIN_ZERO;
                  res_data_r  <= mac_result;
                  res_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               in_ready_r  <= 1'b0;
               res_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // Output ports straight from registers.
   always_comb begin
      in_ready  = in_ready_r;
      mac_a     = mac_a_r;
      mac_b     = mac_b_r;
      mac_en    = mac_en_r;
      mac_clr   = mac_clr_r;
      res_data  = res_data_r;
      res_valid = res_valid_r;
      busy      = busy_r;
   end

endmodule
